// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between a CPU requester (0)
// and a debug/bootloader requester (1); sequences address issue, latency wait and capture.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  we0,
  output logic                  done0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  we1,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  owner,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int unsigned CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  grant;
  logic                  done0_d, done1_d, busy_d, owner_d, mwe_d;
  logic [DATA_WIDTH-1:0] rdata_d, din_d;
  logic [ADDR_WIDTH-1:0] addr_d;

  // Next-state and next-output logic; owner doubles as the last-grant pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    owner_d = owner;
    addr_d  = mem_address;
    din_d   = mem_data_in;
    rdata_d = rdata;
    mwe_d   = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    grant   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant   = (req0 && req1) ? ~owner : req1;
          owner_d = grant;
          addr_d  = grant ? addr1 : addr0;
          din_d   = grant ? wdata1 : wdata0;
          we_d    = grant ? we1 : we0;
          // Strobe is raised at the grant edge so it is high during ACCESS only.
          mwe_d   = grant ? we1 : we0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          done0_d = ~owner;
          done1_d = owner;
          state_d = DONE;
        end else begin
          cnt_d   = CNT_WIDTH'(READ_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_WIDTH'(1)) begin
          rdata_d = mem_data_out;
          done0_d = ~owner;
          done1_d = owner;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      we_q             <= 1'b0;
      done0            <= 1'b0;
      done1            <= 1'b0;
      rdata            <= '0;
      busy             <= 1'b0;
      owner            <= 1'b1;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_write_enable <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      we_q             <= we_d;
      done0            <= done0_d;
      done1            <= done1_d;
      rdata            <= rdata_d;
      busy             <= busy_d;
      owner            <= owner_d;
      mem_address      <= addr_d;
      mem_data_in      <= din_d;
      mem_write_enable <= mwe_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level model (round-robin winner, access latency, expected memory contents).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        done0, done1, busy, owner, mem_write_enable;
  logic [7:0]  rdata, mem_data_in, mem_data_out;
  logic [15:0] mem_address;

  logic        l3_req;
  logic [15:0] l3_addr;
  logic        l3_done0, l3_done1, l3_busy, l3_owner, l3_mwe;
  logic [7:0]  l3_rdata, l3_mdin, l3_mout;
  logic [15:0] l3_maddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .done0(done0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .done1(done1),
    .rdata(rdata), .busy(busy), .owner(owner),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out)
  );

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(l3_req), .addr0(l3_addr), .wdata0(8'h00), .we0(1'b0), .done0(l3_done0),
    .req1(1'b0), .addr1(16'h0000), .wdata1(8'h00), .we1(1'b0), .done1(l3_done1),
    .rdata(l3_rdata), .busy(l3_busy), .owner(l3_owner),
    .mem_address(l3_maddr), .mem_data_in(l3_mdin),
    .mem_write_enable(l3_mwe), .mem_data_out(l3_mout)
  );

  // Power-on memory image; unwritten locations read this pattern.
  function automatic logic [7:0] init_pat(input logic [7:0] a);
    case (a)
      8'h05:   return 8'hA9;
      8'h06:   return 8'h3C;
      8'h02:   return 8'h7E;
      default: return 8'(a * 8'd37 + 8'd11);
    endcase
  endfunction

  // Memory behind dut: registered read, one cycle latency.
  bit [7:0] mem_a [256];
  bit       wr_a  [256];
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem_a[mem_address[7:0]] <= mem_data_in;
      wr_a[mem_address[7:0]]  <= 1'b1;
    end
    mem_data_out <= wr_a[mem_address[7:0]] ? mem_a[mem_address[7:0]] : init_pat(mem_address[7:0]);
  end

  // Read-only memory behind dut3 with a three-stage read pipeline.
  logic [7:0] l3_p0, l3_p1;
  always @(posedge clk) begin
    l3_p0   <= init_pat(l3_maddr[7:0]);
    l3_p1   <= l3_p0;
    l3_mout <= l3_p1;
  end

  // Expected memory contents.
  bit [7:0] ref_val [256];
  bit       ref_wr  [256];
  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_wr[a[7:0]] ? ref_val[a[7:0]] : init_pat(a[7:0]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; l3_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; we0 = 1'b0; we1 = 1'b0; l3_addr = '0;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; l3_req = 1'b1;
    step();
    step();
    total++;
    if ({done0, done1, busy, owner, mem_write_enable} !== 5'b00010) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00010", {done0, done1, busy, owner, mem_write_enable});
    end
    total++;
    if ({rdata, mem_address, mem_data_in} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", {rdata, mem_address, mem_data_in});
    end
    total++;
    if ({l3_done0, l3_done1, l3_busy, l3_owner, l3_mwe} !== 5'b00010) begin
      bad++;
      $display("FAIL reset_l3 got=%b exp=00010", {l3_done0, l3_done1, l3_busy, l3_owner, l3_mwe});
    end
    req0 = 1'b0; req1 = 1'b0; l3_req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    req0 = 1'b1; addr0 = 16'h0005; we0 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) req0 = 1'b0;
      total++;
      if (done1 !== 1'b0) begin
        bad++;
        $display("FAIL read_done1 cycle=%0d got=%b exp=0", c, done1);
      end
      if (c <= 3) begin
        total++;
        if (mem_address !== 16'h0005 || busy !== 1'b1) begin
          bad++;
          $display("FAIL read_addr cycle=%0d got=%h/%b exp=0005/1", c, mem_address, busy);
        end
      end
      total++;
      if (done0 !== (c == 3)) begin
        bad++;
        $display("FAIL read_done0 cycle=%0d got=%b exp=%b", c, done0, c == 3);
      end
      if (c == 3) begin
        total++;
        if (rdata !== 8'hA9) begin
          bad++;
          $display("FAIL read_rdata got=%h exp=a9", rdata);
        end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_single_write();
    req1 = 1'b1; addr1 = 16'h0010; wdata1 = 8'h42; we1 = 1'b1;
    step();
    total++;
    if ({mem_write_enable, mem_address, mem_data_in} !== {1'b1, 16'h0010, 8'h42}) begin
      bad++;
      $display("FAIL write_issue got=%b/%h/%h exp=1/0010/42", mem_write_enable, mem_address, mem_data_in);
    end
    step();
    total++;
    if ({mem_write_enable, done1, done0} !== 3'b010) begin
      bad++;
      $display("FAIL write_done got=%b exp=010", {mem_write_enable, done1, done0});
    end
    ref_wr[8'h10] = 1'b1; ref_val[8'h10] = 8'h42;
    req1 = 1'b0; we1 = 1'b0;
    step();
    req0 = 1'b1; addr0 = 16'h0010; we0 = 1'b0;
    step();
    step();
    step();
    total++;
    if ({done0, done1, mem_write_enable} !== 3'b100 || rdata !== ref_read(16'h0010)) begin
      bad++;
      $display("FAIL write_reread got=%b/%h exp=100/%h", {done0, done1, mem_write_enable}, rdata, ref_read(16'h0010));
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_contention();
    logic [15:0] a0, a1, a;
    int exp_own;
    int k;
    do_reset();
    a0 = 16'h0001; a1 = 16'h0002; exp_own = 0;
    req0 = 1'b1; addr0 = a0; we0 = 1'b0;
    req1 = 1'b1; addr1 = a1; we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin
        step();
        k++;
      end while (!(done0 || done1) && k < 8);
      a = (exp_own == 1) ? a1 : a0;
      total++;
      if ({done0, done1} !== ((exp_own == 1) ? 2'b01 : 2'b10) || owner !== 1'(exp_own)) begin
        bad++;
        $display("FAIL contention_grant n=%0d got=%b owner=%b exp_owner=%0d", i, {done0, done1}, owner, exp_own);
      end
      total++;
      if (rdata !== ref_read(a)) begin
        bad++;
        $display("FAIL contention_rdata n=%0d got=%h exp=%h", i, rdata, ref_read(a));
      end
      step();
      if (exp_own == 1) begin a1 = a1 + 16'd2; addr1 = a1; end
      else begin a0 = a0 + 16'd2; addr0 = a0; end
      exp_own = 1 - exp_own;
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_latency3();
    l3_req = 1'b1; l3_addr = 16'h0002;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        total++;
        if (l3_maddr !== 16'h0002 || l3_done0 !== 1'b0) begin
          bad++;
          $display("FAIL lat3_wait cycle=%0d got=%h/%b exp=0002/0", c, l3_maddr, l3_done0);
        end
      end else begin
        total++;
        if ({l3_done0, l3_done1} !== 2'b10 || l3_rdata !== 8'h7E) begin
          bad++;
          $display("FAIL lat3_done got=%b/%h exp=10/7e", {l3_done0, l3_done1}, l3_rdata);
        end
      end
    end
    l3_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; addr0 = 16'h0005; we0 = 1'b0;
    step();
    step();
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    total++;
    if ({busy, done0, done1, mem_write_enable} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_read got=%b exp=0000", {busy, done0, done1, mem_write_enable});
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({done0, done1} !== 2'b00) begin
        bad++;
        $display("FAIL rst_read_quiet cycle=%0d got=%b exp=00", c, {done0, done1});
      end
    end
    req1 = 1'b1; addr1 = 16'h0020; wdata1 = 8'h55; we1 = 1'b1;
    step();
    // The strobe already went out during this ACCESS cycle, so the location holds the new value.
    ref_wr[8'h20] = 1'b1; ref_val[8'h20] = 8'h55;
    reset = 1'b1; req1 = 1'b0; we1 = 1'b0;
    step();
    reset = 1'b0;
    total++;
    if ({busy, done0, done1, mem_write_enable} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_write got=%b exp=0000", {busy, done0, done1, mem_write_enable});
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({done0, done1, mem_write_enable} !== 3'b000) begin
        bad++;
        $display("FAIL rst_write_quiet cycle=%0d got=%b exp=000", c, {done0, done1, mem_write_enable});
      end
    end
    req0 = 1'b1; addr0 = 16'h0005; we0 = 1'b0;
    step();
    step();
    step();
    total++;
    if ({done0, done1} !== 2'b10 || rdata !== 8'hA9) begin
      bad++;
      $display("FAIL rst_recover got=%b/%h exp=10/a9", {done0, done1}, rdata);
    end
    req0 = 1'b0;
    step();
  endtask

  task automatic test_input_change();
    req0 = 1'b1; addr0 = 16'h0005; we0 = 1'b0;
    step();
    step();
    addr0 = 16'h0006;
    total++;
    if (mem_address !== 16'h0005) begin
      bad++;
      $display("FAIL change_addr got=%h exp=0005", mem_address);
    end
    step();
    total++;
    if ({done0, mem_address} !== {1'b1, 16'h0005} || rdata !== ref_read(16'h0005)) begin
      bad++;
      $display("FAIL change_rdata got=%b/%h/%h exp=1/0005/%h", done0, mem_address, rdata, ref_read(16'h0005));
    end
    req0 = 1'b0;
    step();
  endtask

  // Random traffic: whenever the port is idle the model picks the winner from the
  // pending set and last grant, predicts the done cycle and the returned data.
  task automatic test_random(input int n);
    bit          p0, p1, w0, w1, wr;
    logic [15:0] a0, a1, a;
    logic [7:0]  d0, d1, d;
    int          last, win, lat;
    do_reset();
    last = 1; p0 = 1'b0; p1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; w0 = 1'b0; w1 = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; a0 = 16'($urandom_range(0, 15)); d0 = 8'($urandom); w0 = 1'($urandom);
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; a1 = 16'($urandom_range(0, 15)); d1 = 8'($urandom); w1 = 1'($urandom);
      end
      req0 = p0; addr0 = a0; wdata0 = d0; we0 = w0;
      req1 = p1; addr1 = a1; wdata1 = d1; we1 = w1;
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL rand_idle t=%0d busy=%b exp=0", t, busy);
      end
      if (!p0 && !p1) begin
        step();
        continue;
      end
      win = (p0 && p1) ? 1 - last : (p1 ? 1 : 0);
      wr  = (win == 1) ? w1 : w0;
      a   = (win == 1) ? a1 : a0;
      d   = (win == 1) ? d1 : d0;
      lat = wr ? 2 : 3;
      for (int k = 1; k <= lat; k++) begin
        step();
        if (k < lat) begin
          total++;
          if ({done0, done1} !== 2'b00) begin
            bad++;
            $display("FAIL rand_early t=%0d k=%0d got=%b exp=00", t, k, {done0, done1});
          end
        end
      end
      total++;
      if ({done0, done1} !== ((win == 1) ? 2'b01 : 2'b10)) begin
        bad++;
        $display("FAIL rand_done t=%0d got=%b winner=%0d", t, {done0, done1}, win);
      end
      if (wr) begin
        ref_wr[a[7:0]] = 1'b1; ref_val[a[7:0]] = d;
      end else begin
        total++;
        if (rdata !== ref_read(a)) begin
          bad++;
          $display("FAIL rand_rdata t=%0d addr=%h got=%h exp=%h", t, a, rdata, ref_read(a));
        end
      end
      last = win;
      if (win == 1) begin p1 = 1'b0; req1 = 1'b0; end
      else begin p0 = 1'b0; req0 = 1'b0; end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_latency3();
    test_reset_mid();
    test_input_change();
    test_random(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one synchronous on-FPGA memory port (registered read data, fixed read latency) between two requesters.
- Requester 0 is the CPU fetch/load-store unit; requester 1 is the debug/bootloader port that loads the memory image over UART.
- Sequences each access (address issue, latency wait, data capture) and arbitrates round-robin between the two requesters.

Parameters:
- ADDR_WIDTH, 16, width of requester and memory addresses
- DATA_WIDTH, 8, data width
- READ_LATENCY, 1, cycles from address presented to mem_data_out valid; legal 1..7

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- req0  input  1  requester 0 access request, held until done0
- addr0  input  ADDR_WIDTH  requester 0 address
- wdata0  input  DATA_WIDTH  requester 0 write data
- we0  input  1  requester 0 write (1) / read (0)
- done0  output  1  one-cycle completion pulse to requester 0
- req1, addr1, wdata1, we1  input  1/ADDR_WIDTH/DATA_WIDTH/1  same meaning for requester 1
- done1  output  1  one-cycle completion pulse to requester 1
- rdata  output  DATA_WIDTH  read data; valid in the cycle doneN is high
- busy  output  1  high in every state except IDLE
- owner  output  1  requester currently or last granted
- mem_address  output  ADDR_WIDTH  to memory
- mem_data_in  output  DATA_WIDTH  to memory, write data
- mem_write_enable  output  1  to memory, one-cycle write strobe
- mem_data_out  input  DATA_WIDTH  from memory, registered read data

Behaviour:
- All outputs are registered.
- Reset values: done0=done1=0, rdata=0, busy=0, owner=1, mem_address=0, mem_data_in=0, mem_write_enable=0, state IDLE, latency counter 0, last-grant pointer=1.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Sample req0/req1.
  - If only one is set, grant it.
  - If both are set, grant the requester that is not the last-granted one (after reset, requester 0 wins the first tie).
  - On grant: latch address, wdata and we into mem_address/mem_data_in/internal we; set owner; update last-grant; go to ACCESS.
  - If no request, stay in IDLE.
- ACCESS (1 cycle):
  - mem_address stable.
  - If write: mem_write_enable=1 for exactly this cycle, next state DONE.
  - If read: mem_write_enable=0, load counter with READ_LATENCY, next state WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter reaches 1, capture mem_data_out into rdata at that edge and go to DONE.
  - mem_address held stable throughout.
- DONE (1 cycle):
  - done[owner]=1, other done=0.
  - rdata holds captured data for reads; unchanged for writes.
  - req inputs are ignored in this state.
  - Next state IDLE.
- Timing:
  - Read: req asserted in cycle 0 gives done in cycle 2+READ_LATENCY (cycle 3 at default).
  - Write: req asserted in cycle 0 gives done in cycle 2.
  - Back-to-back accesses cost one IDLE cycle each.
- Handshake:
  - Requester holds req, addr, wdata and we stable until it sees doneN, then deasserts req by the following cycle.
  - Inputs are sampled only in IDLE; changes during an access are ignored.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1,…; neither can starve.
- Non-requesting side: a requester never receives done unless it was granted.
- Reset mid-operation:
  - Abort immediately, return to reset values next cycle.
  - No done pulse.
  - mem_write_enable=0 from the next cycle; a write in ACCESS during the reset cycle must not be reissued.
- Address width: addresses pass through unmodified; region decode (ROM/RAM select, 1 KiB ROM aliasing) belongs to the memory side.

Test Plan:
- Single read: reset, req0=1 addr0=0x0005 we0=0, memory returns 0xA9 at addr 5 → mem_address=0x0005 from cycle 1, done0=1 in cycle 3, rdata=0xA9, done1 never high.
- Single write: req1=1 addr1=0x0010 wdata1=0x42 we1=1 → mem_write_enable=1 for exactly one cycle (cycle 1) with mem_address=0x0010, mem_data_in=0x42; done1 in cycle 2; re-read of 0x0010 via req0 returns 0x42.
- Contention: req0 and req1 both held high over 4 accesses → grant order 0,1,0,1; owner toggles; each done goes only to its owner; rdata matches each addressed location.
- Latency param: READ_LATENCY=3, read addr 0x0002 holding 0x7E → done0 in cycle 5, rdata=0x7E; mem_address stable cycles 1–4.
- Reset mid-access: assert reset during WAIT of a read and during ACCESS of a write → next cycle busy=0, done0=done1=0, mem_write_enable=0; no done ever pulses for the aborted access; the next req0 after reset is serviced normally.
- Input change mid-access: change addr0 from 0x0005 to 0x0006 during WAIT → mem_address stays 0x0005, rdata is data from 0x0005.
